// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: queued command word, FSM states
// and timer width.
package i2c_pkg;

    localparam int I2C_TIMEOUT_W = 16;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_RESP
    } seq_state_e;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Show-ahead synchronous FIFO of i2c_cmd_t. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
module i2c_cmd_fifo
    import i2c_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  i2c_cmd_t din,
    output i2c_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    i2c_cmd_t    mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset: a flush only needs the pointers cleared.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C byte commands and drives them one at a time into i2c_master,
// returning one registered response (read data, NACK or timeout) per command.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic [6:0] m_addr,
    output logic       m_rw,
    output logic [7:0] m_data_w,
    output logic       m_start,
    input  logic [7:0] m_data_out,
    input  logic       m_valid_out,
    input  logic       m_busy,
    input  logic       m_erro_addr
);

    localparam logic [I2C_TIMEOUT_W-1:0] TIMER_LAST = I2C_TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [I2C_TIMEOUT_W-1:0] TIMER_ONE  = 1;

    seq_state_e                 state;
    logic [I2C_TIMEOUT_W-1:0]   timer;
    logic [7:0]                 rdata_q;
    logic                       err_q;

    i2c_cmd_t fifo_din;
    i2c_cmd_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_pop;

    logic       timeout_hit;
    logic       err_nx;
    logic [7:0] rdata_nx;

    assign cmd_ready = !fifo_full;
    assign fifo_din  = '{addr: cmd_addr, rw: cmd_rw, wdata: cmd_wdata};
    // The head entry stays queued until its response goes out.
    assign fifo_pop  = (state == ST_RESP);

    i2c_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Timer counts from the ISSUE cycle, so the response lands TIMEOUT_CYC cycles after m_start.
    assign timeout_hit = (timer == TIMER_LAST);
    assign err_nx      = err_q | m_erro_addr;
    assign rdata_nx    = (state == ST_RUN && m_valid_out) ? m_data_out : rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            m_addr      <= '0;
            m_rw        <= 1'b0;
            m_data_w    <= '0;
            m_start     <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            m_start     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && !m_busy) begin
                        state    <= ST_ISSUE;
                        m_start  <= 1'b1;
                        m_addr   <= head.addr;
                        m_rw     <= head.rw;
                        m_data_w <= head.wdata;
                        timer    <= '0;
                        rdata_q  <= '0;
                        err_q    <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    timer <= timer + TIMER_ONE;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_RUN: begin
                    timer   <= timer + TIMER_ONE;
                    err_q   <= err_nx;
                    rdata_q <= rdata_nx;
                    if (timeout_hit || (state == ST_WAIT_BUSY && m_erro_addr)
                        || (state == ST_RUN && !m_busy)) begin
                        state       <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= err_nx;
                        rsp_timeout <= timeout_hit;
                        rsp_rdata   <= (err_nx || timeout_hit) ? 8'h00 : rdata_nx;
                    end else if (state == ST_WAIT_BUSY && m_busy) begin
                        state <= ST_RUN;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: a behavioural I2C master answers each start,
// and every response is compared with the outcome predicted from the command.
module tb_i2c_cmd_sequencer;

    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 20;
    localparam int M_OK = 0, M_NACK = 1, M_NACK_EARLY = 2, M_TO = 3;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        int         mode;
        int         hold;
        logic [7:0] rdata;
    } tb_cmd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rw;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic [6:0] m_addr;
    logic       m_rw;
    logic [7:0] m_data_w;
    logic       m_start;
    logic [7:0] m_data_out;
    logic       m_valid_out;
    logic       m_busy;
    logic       m_erro_addr;
    logic       model_busy;
    logic       ext_busy;

    assign m_busy = model_busy | ext_busy;

    i2c_cmd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_rw      (cmd_rw),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .m_addr      (m_addr),
        .m_rw        (m_rw),
        .m_data_w    (m_data_w),
        .m_start     (m_start),
        .m_data_out  (m_data_out),
        .m_valid_out (m_valid_out),
        .m_busy      (m_busy),
        .m_erro_addr (m_erro_addr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         tests_run = 0;
    int         tests_failed = 0;
    tb_cmd_t    mq[$];
    logic [9:0] exp_q[$];
    int         start_q[$];
    int         epoch = 0;
    int         push_cyc = 0;
    logic       lat_armed = 1'b0;
    logic       prev_start = 1'b0;
    int         rsp_seen = 0;
    int         start_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic tb_cmd_t mk(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                                   input int mode, input int hold, input logic [7:0] rd);
        tb_cmd_t c;
        c.addr = a; c.rw = rw; c.wdata = wd; c.mode = mode; c.hold = hold; c.rdata = rd;
        return c;
    endfunction

    // Response the host should see: {rdata, err, timeout}.
    function automatic logic [9:0] model_rsp(input tb_cmd_t c);
        if (c.mode == M_TO) return {8'h00, 1'b0, 1'b1};
        if (c.mode == M_NACK || c.mode == M_NACK_EARLY) return {8'h00, 1'b1, 1'b0};
        if (c.rw) return {c.rdata, 1'b0, 1'b0};
        return 10'd0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input tb_cmd_t c, output bit acc);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = c.addr;
        cmd_rw    = c.rw;
        cmd_wdata = c.wdata;
        acc = cmd_ready;
        if (acc) begin
            mq.push_back(c);
            exp_q.push_back(model_rsp(c));
            push_cyc = cyc;
        end
    endtask

    task automatic idle_cmd;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send(input tb_cmd_t c);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 500 && !acc; i++) push_cmd(c, acc);
        idle_cmd();
        if (!acc) check_eq("send_accept", 0, 1);
    endtask

    task automatic drain;
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || m_busy); i++) @(negedge clk);
        check_eq("drain_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- behavioural I2C master ----------------
    initial begin : master_model
        tb_cmd_t c;
        int ep;
        model_busy  = 1'b0;
        m_valid_out = 1'b0;
        m_data_out  = 8'h00;
        m_erro_addr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (m_start && !rst) begin
                ep = epoch;
                if (mq.size() == 0) begin
                    check_eq("unexpected_start", 1, 0);
                end else begin
                    c = mq.pop_front();
                    start_q.push_back(cyc);
                    check_eq("m_addr", m_addr, c.addr);
                    check_eq("m_rw", m_rw, c.rw);
                    check_eq("m_data_w", m_data_w, c.wdata);
                    if (lat_armed) begin
                        check_eq("start_latency", cyc - push_cyc, 2);
                        lat_armed = 1'b0;
                    end
                    @(negedge clk);
                    if (c.mode == M_NACK_EARLY) begin
                        @(negedge clk);
                        m_erro_addr = 1'b1;
                        @(negedge clk);
                        m_erro_addr = 1'b0;
                    end else begin
                        model_busy = 1'b1;
                        repeat (c.mode == M_TO ? 30 : c.hold) @(negedge clk);
                        if (ep == epoch)
                            check_eq("m_fields_held", {m_addr, m_rw, m_data_w}, {c.addr, c.rw, c.wdata});
                        if (c.mode == M_OK && c.rw) begin
                            m_valid_out = 1'b1;
                            m_data_out  = c.rdata;
                            @(negedge clk);
                            m_valid_out = 1'b0;
                            m_data_out  = 8'h00;
                        end else if (c.mode == M_NACK) begin
                            m_erro_addr = 1'b1;
                            @(negedge clk);
                            m_erro_addr = 1'b0;
                        end
                        model_busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    always @(posedge clk) begin
        logic [9:0] e;
        int sc;
        #1;
        if (!rst) begin
            if (m_start) begin
                start_seen++;
                check_eq("start_pulse_width", prev_start, 0);
                check_eq("no_start_while_busy", m_busy, 0);
            end
            if (rsp_valid) begin
                rsp_seen++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_rsp", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    sc = (start_q.size() != 0) ? start_q.pop_front() : -1000;
                    check_eq("rsp", {rsp_rdata, rsp_err, rsp_timeout}, e);
                    if (e[0]) check_eq("timeout_latency", cyc - sc, TIMEOUT_CYC);
                end
            end
        end
        prev_start = m_start;
    end

    // ---------------- main sequence ----------------
    initial begin
        tb_cmd_t c;
        bit acc;
        int n_acc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_wdata = '0; ext_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, 0);
        check_eq("reset_m_start", m_start, 0);
        check_eq("reset_m_fields", {m_addr, m_rw, m_data_w}, 0);
        check_eq("reset_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // write with ACK, plus push-to-start latency
        lat_armed = 1'b1;
        send(mk(7'h50, 1'b0, 8'hA5, M_OK, 4, 8'h00));
        drain();
        check_eq("latency_checked", lat_armed, 0);

        // read returning 0x7E
        send(mk(7'h3C, 1'b1, 8'h00, M_OK, 3, 8'h7E));
        drain();

        // address NACK on a read, with a write queued behind it
        c = mk(7'h3C, 1'b1, 8'h00, M_NACK, 3, 8'hFF);
        push_cmd(c, acc);
        c = mk(7'h21, 1'b0, 8'h33, M_OK, 2, 8'h00);
        push_cmd(c, acc);
        idle_cmd();
        drain();

        // backpressure: five pushes while the master is held busy
        @(negedge clk);
        ext_busy = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            c = mk(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   M_OK, $urandom_range(2, 6), 8'($urandom_range(0, 255)));
            push_cmd(c, acc);
            if (acc) n_acc++;
        end
        idle_cmd();
        check_eq("bp_accepted", n_acc, FIFO_DEPTH);
        check_eq("bp_ready_low", cmd_ready, 0);
        repeat (4) @(negedge clk);
        ext_busy = 1'b0;
        drain();

        // timeout with a command queued behind it
        send(mk(7'h2A, 1'b0, 8'h99, M_TO, 0, 8'h00));
        send(mk(7'h2B, 1'b1, 8'h00, M_OK, 3, 8'h5A));
        drain();

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            c = mk(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   (r < 6) ? M_OK : (r < 7) ? M_NACK : (r < 8) ? M_NACK_EARLY : M_TO,
                   $urandom_range(2, 8), 8'($urandom_range(0, 255)));
            send(c);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        // reset while a command runs with two more queued
        send(mk(7'h11, 1'b0, 8'h22, M_OK, 15, 8'h00));
        c = mk(7'h12, 1'b1, 8'h00, M_OK, 3, 8'h44);
        push_cmd(c, acc);
        c = mk(7'h13, 1'b0, 8'h55, M_OK, 3, 8'h00);
        push_cmd(c, acc);
        idle_cmd();
        for (int i = 0; i < 50 && start_q.size() == 0; i++) @(negedge clk);
        check_eq("rst_test_started", start_q.size(), 1);
        repeat (5) @(negedge clk);
        epoch++;
        rst = 1'b1;
        #1;
        mq.delete();
        exp_q.delete();
        start_q.delete();
        check_eq("midrst_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
        check_eq("midrst_m_start", m_start, 0);
        check_eq("midrst_m_fields", {m_addr, m_rw, m_data_w}, 0);
        check_eq("midrst_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rsp_seen = 0;
        start_seen = 0;
        repeat (40) @(negedge clk);
        check_eq("post_rst_rsp_count", rsp_seen, 0);
        check_eq("post_rst_start_count", start_seen, 0);
        check_eq("post_rst_cmd_ready", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
